// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field bit positions and exception codes.
// Pure constants and one alignment helper; no state, no latency.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/cp0.sv
// CP0 exception/interrupt control (SR, Cause, EPC, PRId); IntReq and RData are combinational,
// register updates land one edge later; no backpressure, the pipeline must act on IntReq immediately.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h4D495053
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  Addr,
  input  logic        We,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPCOut
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend, exc_pend, int_req;
  logic        sr_wr, epc_wr;
  logic [31:0] pc_aligned;
  logic [31:0] sr_word, cause_word;

  always_comb begin
    int_pend = (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_pend = (ExcCode != EXC_INT) & ~exl_q;
    int_req  = int_pend | exc_pend;
    sr_wr    = We & (Addr == REG_SR);
    epc_wr   = We & (Addr == REG_EPC);
  end

  assign IntReq = int_req;
  assign EPCOut = epc_q;

  // Taking an exception/interrupt masks any mtc0 or eret in the same cycle.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    if (int_req) begin
      exl_d = 1'b1;
    end else begin
      if (sr_wr) begin
        im_d  = WData[SR_IM_MSB:SR_IM_LSB];
        exl_d = WData[SR_EXL_BIT];
        ie_d  = WData[SR_IE_BIT];
      end
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
    end
  end

  always_comb begin
    ip_d       = HWInt;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    if (int_req) begin
      bd_d       = BD;
      exc_code_d = int_pend ? EXC_INT : ExcCode;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ip_q       <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
    end else begin
      ip_q       <= ip_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
    end
  end

  // A delay-slot victim restarts at the branch, one word earlier.
  always_comb begin
    pc_aligned = word_align(PC);
    epc_d      = epc_q;
    if (int_req) epc_d = BD ? (pc_aligned - 32'd4) : pc_aligned;
    else if (epc_wr) epc_d = word_align(WData);
  end

  always_ff @(posedge Clk) begin
    if (Reset) epc_q <= '0;
    else       epc_q <= epc_d;
  end

  always_comb begin
    sr_word                            = '0;
    sr_word[SR_IM_MSB:SR_IM_LSB]       = im_q;
    sr_word[SR_EXL_BIT]                = exl_q;
    sr_word[SR_IE_BIT]                 = ie_q;
    cause_word                         = '0;
    cause_word[CAUSE_BD_BIT]           = bd_q;
    cause_word[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip_q;
    cause_word[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code_q;
    case (Addr)
      REG_SR:    RData = sr_word;
      REG_CAUSE: RData = cause_word;
      REG_EPC:   RData = epc_q;
      REG_PRID:  RData = PRID_VALUE;
      default:   RData = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: directed vector table for the exception/interrupt corner cases,
// then randomized traffic against a word-level reference model.
module tb_cp0;
  import cp0_pkg::*;

  localparam logic [31:0] PRID = 32'h4D495053;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0 #(.PRID_VALUE(PRID)) dut (
    .Clk(clk), .Reset(reset), .Addr(addr), .We(we), .WData(wdata), .RData(rdata),
    .PC(pc), .BD(bd), .ExcCode(exc_code), .HWInt(hw_int), .EXLClr(exl_clr),
    .IntReq(int_req), .EPCOut(epc_out)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exlclr;
    logic        exp_irq;
    logic [31:0] exp_rdata;
    logic [31:0] exp_epc;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic [4:0] a, input logic w,
                             input logic [31:0] wd, input logic [31:0] p, input logic b,
                             input logic [4:0] e, input logic [5:0] h, input logic xc,
                             input logic irq, input logic [31:0] rd, input logic [31:0] ep);
    vec_t r;
    r.rst = rst; r.addr = a; r.we = w; r.wdata = wd; r.pc = p; r.bd = b;
    r.exc = e; r.hw = h; r.exlclr = xc; r.exp_irq = irq; r.exp_rdata = rd; r.exp_epc = ep;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %08h want %08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [4:0] a, input logic w,
                       input logic [31:0] wd, input logic [31:0] p, input logic b,
                       input logic [4:0] e, input logic [5:0] h, input logic xc);
    @(negedge clk);
    reset = rst; addr = a; we = w; wdata = wd; pc = p; bd = b;
    exc_code = e; hw_int = h; exl_clr = xc;
    #1;
  endtask

  vec_t tbl[28];

  // Reference model state, held as whole architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  initial begin
    logic        ip_hit, e_int, e_exc, e_req;
    logic [31:0] e_rd;
    logic        r_rst, r_we, r_bd, r_xc;
    logic [4:0]  r_addr, r_exc;
    logic [31:0] r_wd, r_pc;
    logic [5:0]  r_hw;

    reset = 1'b1; addr = '0; we = 1'b0; wdata = '0; pc = '0; bd = 1'b0;
    exc_code = '0; hw_int = '0; exl_clr = 1'b0;
    repeat (2) @(posedge clk);

    //          rst addr we wdata          pc       bd exc hw   xc  irq rdata          epc
    tbl[0]  = v(1, 12, 0, 0,             0,       0, 0,  0,   0,  0, 0,             0);
    tbl[1]  = v(0, 13, 0, 0,             0,       0, 0,  0,   0,  0, 0,             0);
    tbl[2]  = v(0, 12, 1, 32'h401,       0,       0, 0,  0,   0,  0, 0,             0);
    tbl[3]  = v(0, 12, 0, 0,             32'h3010,0, 0,  1,   0,  1, 32'h401,       0);
    tbl[4]  = v(0, 14, 0, 0,             32'h3014,0, 0,  1,   0,  0, 32'h3010,      32'h3010);
    tbl[5]  = v(0, 13, 0, 0,             0,       0, 0,  1,   0,  0, 32'h400,       32'h3010);
    tbl[6]  = v(0, 12, 0, 0,             0,       0, 0,  1,   0,  0, 32'h403,       32'h3010);
    tbl[7]  = v(0, 12, 0, 0,             0,       0, 0,  1,   1,  0, 32'h403,       32'h3010);
    tbl[8]  = v(0, 12, 0, 0,             32'h3040,0, 0,  1,   0,  1, 32'h401,       32'h3010);
    tbl[9]  = v(0, 12, 1, 32'h1,         0,       0, 0,  0,   1,  0, 32'h403,       32'h3040);
    tbl[10] = v(0, 13, 0, 0,             32'h3024,1, EXC_OV, 0, 0, 1, 0,            32'h3040);
    tbl[11] = v(0, 13, 1, 32'hFFFFFFFF,  0,       0, 0,  0,   0,  0, 32'h80000030,  32'h3020);
    tbl[12] = v(0, 13, 0, 0,             0,       0, 0,  0,   1,  0, 32'h80000030,  32'h3020);
    tbl[13] = v(0, 14, 1, 32'h3007,      0,       0, 0,  0,   0,  0, 32'h3020,      32'h3020);
    tbl[14] = v(0, 14, 0, 0,             0,       0, 0,  0,   0,  0, 32'h3004,      32'h3004);
    tbl[15] = v(0, 12, 1, 32'h801,       0,       0, 0,  0,   0,  0, 32'h001,       32'h3004);
    tbl[16] = v(0, 12, 0, 0,             32'h3050,0, EXC_RI, 2, 0, 1, 32'h801,      32'h3004);
    tbl[17] = v(0, 13, 0, 0,             0,       0, 0,  0,   0,  0, 32'h800,       32'h3050);
    tbl[18] = v(0, 12, 0, 0,             0,       0, 0,  0,   1,  0, 32'h803,       32'h3050);
    tbl[19] = v(0, 14, 1, 32'h1234,      32'h3060,1, 0,  2,   1,  1, 32'h3050,      32'h3050);
    tbl[20] = v(0, 12, 0, 0,             0,       0, 0,  0,   0,  0, 32'h803,       32'h305C);
    tbl[21] = v(0, 13, 0, 0,             0,       0, 0,  0,   1,  0, 32'h80000000,  32'h305C);
    tbl[22] = v(1, 15, 0, 0,             32'h3070,0, 0,  2,   0,  1, PRID,          32'h305C);
    tbl[23] = v(0, 12, 0, 0,             0,       0, 0,  0,   0,  0, 0,             0);
    tbl[24] = v(0, 13, 0, 0,             0,       0, 0,  0,   0,  0, 0,             0);
    tbl[25] = v(0, 14, 0, 0,             0,       0, 0,  0,   0,  0, 0,             0);
    tbl[26] = v(0, 15, 1, 0,             0,       0, 0,  0,   0,  0, PRID,          0);
    tbl[27] = v(0, 3,  0, 0,             0,       0, 0,  0,   0,  0, 0,             0);

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].rst, tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].pc, tbl[i].bd,
            tbl[i].exc, tbl[i].hw, tbl[i].exlclr);
      check("vec_irq",   i, {31'b0, int_req}, {31'b0, tbl[i].exp_irq});
      check("vec_rdata", i, rdata,   tbl[i].exp_rdata);
      check("vec_epc",   i, epc_out, tbl[i].exp_epc);
    end

    // Eret in the cycle after an interrupt is taken must be ignored: EXL stays set.
    drive(0, 12, 1, 32'h0000_0401, 0, 0, 0, 0, 0);
    drive(0, 12, 0, 0, 32'h4000, 0, 0, 6'h01, 1);
    check("hs_take_irq", 0, {31'b0, int_req}, 32'd1);
    drive(0, 12, 0, 0, 0, 0, 0, 6'h01, 0);
    check("hs_exl_set", 0, rdata, 32'h403);
    check("hs_masked", 0, {31'b0, int_req}, 32'd0);
    check("hs_epc", 0, epc_out, 32'h4000);

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    m_sr = '0; m_cause = '0; m_epc = '0;
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 4))
        0: r_addr = REG_SR;
        1: r_addr = REG_CAUSE;
        2: r_addr = REG_EPC;
        3: r_addr = REG_PRID;
        default: r_addr = 5'($urandom_range(0, 31));
      endcase
      r_we = ($urandom_range(0, 3) == 0);
      r_wd = $urandom;
      r_pc = $urandom;
      r_bd = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 7))
        0: r_exc = EXC_ADEL;
        1: r_exc = EXC_ADES;
        2: r_exc = EXC_RI;
        3: r_exc = EXC_OV;
        default: r_exc = 5'd0;
      endcase
      r_hw = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
      r_xc = ($urandom_range(0, 5) == 0);
      drive(r_rst, r_addr, r_we, r_wd, r_pc, r_bd, r_exc, r_hw, r_xc);

      ip_hit = (r_hw & m_sr[15:10]) != 6'd0;
      e_int  = ip_hit && m_sr[0] && !m_sr[1];
      e_exc  = (r_exc != 5'd0) && !m_sr[1];
      e_req  = e_int || e_exc;
      case (r_addr)
        5'd12:   e_rd = m_sr;
        5'd13:   e_rd = m_cause;
        5'd14:   e_rd = m_epc;
        5'd15:   e_rd = PRID;
        default: e_rd = 32'd0;
      endcase
      check("rnd_irq",   n, {31'b0, int_req}, {31'b0, e_req});
      check("rnd_rdata", n, rdata,   e_rd);
      check("rnd_epc",   n, epc_out, m_epc);

      if (r_rst) begin
        m_sr = '0; m_cause = '0; m_epc = '0;
      end else if (e_req) begin
        m_sr    = m_sr | 32'h2;
        m_cause = ({31'b0, r_bd} << 31) | ({26'b0, r_hw} << 10)
                | ({27'b0, (e_int ? 5'd0 : r_exc)} << 2);
        m_epc   = (r_pc & ~32'h3) - (r_bd ? 32'd4 : 32'd0);
      end else begin
        m_cause = (m_cause & ~(32'h3F << 10)) | ({26'b0, r_hw} << 10);
        if (r_we && r_addr == 5'd12) m_sr = r_wd & 32'h0000_FC03;
        if (r_we && r_addr == 5'd14) m_epc = r_wd & ~32'h3;
        if (r_xc) m_sr = m_sr & ~32'h2;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 The block SHALL have parameter PRID_VALUE, default 32'h4D495053, the constant returned when PRId is read.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have port Addr, input, 5, the CP0 register number for mfc0/mtc0.
REQ-005 The block SHALL have port We, input, 1, the mtc0 write enable.
REQ-006 The block SHALL have port WData, input, 32, the mtc0 write data.
REQ-007 The block SHALL have port RData, output, 32, the mfc0 read data.
REQ-008 The block SHALL have port PC, input, 32, the PC of the instruction in the M stage (the victim).
REQ-009 The block SHALL have port BD, input, 1, set when the victim sits in a branch delay slot.
REQ-010 The block SHALL have port ExcCode, input, 5, the pipeline exception code; 0 means no exception.
REQ-011 The block SHALL have port HWInt, input, 6, the hardware interrupt lines; bit 0 is timer0 IntRq and bit 1 is timer1 IntRq.
REQ-012 The block SHALL have port EXLClr, input, 1, asserted while eret is in M.
REQ-013 The block SHALL have port IntReq, output, 1, requesting that the pipeline flush and redirect to the handler.
REQ-014 The block SHALL have port EPCOut, output, 32, the current EPC, used as the eret target.

Function
REQ-015 The block SHALL implement SR as register 12, with IM at bits [15:10], EXL at bit 1 and IE at bit 0; all other bits SHALL read 0.
REQ-016 The block SHALL implement Cause as register 13, with BD at bit 31, IP at bits [15:10] and ExcCode at bits [6:2]; all other bits SHALL read 0; Cause SHALL be read-only to mtc0.
REQ-017 The block SHALL implement EPC as register 14, read/write; bits [1:0] SHALL always be 0.
REQ-018 The block SHALL implement PRId as register 15, reading PRID_VALUE and ignoring writes.
REQ-019 RData SHALL be combinational from Addr; unmapped register numbers SHALL return 32'b0.
REQ-020 IntPend SHALL be (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
REQ-021 ExcPend SHALL be (ExcCode != 0) & ~SR.EXL.
REQ-022 IntReq SHALL be IntPend | ExcPend, combinational with zero latency.
REQ-023 Cause.IP SHALL load HWInt every cycle, regardless of EXL.
REQ-024 On a cycle with IntReq=1, at the next edge the block SHALL set SR.EXL<=1 and Cause.BD<=BD.
REQ-025 On a cycle with IntReq=1, at the next edge Cause.ExcCode SHALL load 0 if IntPend, else ExcCode; interrupt SHALL have priority over exception.
REQ-026 On a cycle with IntReq=1, at the next edge EPC SHALL load {PC[31:2],2'b00} if BD=0, else {PC[31:2],2'b00}-4, with 32-bit wrap.
REQ-027 A cycle with IntReq=1 SHALL ignore We and EXLClr in that same cycle.
REQ-028 EXLClr=1 with IntReq=0 SHALL clear SR.EXL at the next edge; any other SR bits written by a simultaneous We SHALL still apply.
REQ-029 mtc0 to SR SHALL load the IM, EXL and IE fields from WData.
REQ-030 mtc0 to EPC SHALL load {WData[31:2],2'b00}.
REQ-031 While EXL=1, no new IntReq SHALL occur; a pending interrupt SHALL raise IntReq in the first cycle after EXL clears, provided IE and IM still allow it.
REQ-032 EPCOut SHALL equal the EPC register, including the value written by mtc0 in the prior cycle.

Reset
REQ-033 Reset SHALL clear SR, Cause and EPC to 0.
REQ-034 During Reset, RData SHALL still follow Addr, and IntReq SHALL be 0 in the cycle after Reset deasserts unless ExcCode!=0.
REQ-035 Reset SHALL take priority over IntReq, We and EXLClr in the same cycle.

Structure
REQ-036 A shared package SHALL hold the register numbers (12-15), the field bit positions (IM, EXL, IE, BD, IP, ExcCode), and ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
REQ-037 No sub-module SHALL be used; the block SHALL be a single flat module with one update process per register.

Verification
REQ-038 The bench SHALL check: SR=0x0000_0401, HWInt=6'b000001, PC=0x0000_3010, BD=0 -> IntReq=1 same cycle; next cycle EPC=0x3010, ExcCode=0, EXL=1, IntReq=0.
REQ-039 The bench SHALL check: ExcCode=12, BD=1, PC=0x0000_3024, EXL=0 -> IntReq=1; next cycle EPC=0x3020, Cause=0x8000_0030.
REQ-040 The bench SHALL check: same-cycle HWInt[1] enabled and ExcCode=10 -> Cause.ExcCode=0 (interrupt wins), and EPC is taken from that PC.
REQ-041 The bench SHALL check: EXL=1 with HWInt held -> IntReq=0; EXLClr for one cycle -> IntReq=1 on the following cycle.
REQ-042 The bench SHALL check: mtc0 EPC with WData=0x0000_3007 -> RData(14)=0x0000_3004 and EPCOut=0x0000_3004 next cycle; mtc0 Cause with 0xFFFF_FFFF -> Cause unchanged.
REQ-043 The bench SHALL check: Reset asserted during the same cycle as IntReq=1 -> SR, Cause and EPC are all 0 and RData(15)=PRID_VALUE.
